// File: rtl/hrfp_mult_issue_pkg.sv
// Shared definitions for the HRFP multiplier issue/collect front end.
// Holds the format width, the default pipeline latency and a small sizing
// helper used by the FIFO and the top level.
package hrfp_mult_issue_pkg;

  // Most significant bit index of an HRFP word.
  localparam int HRFP_MSBBIT       = 31;
  localparam int HRFP_WIDTH        = HRFP_MSBBIT + 1;
  // Total wrapper + mult latency, from operand register update to result.
  localparam int HRFP_MULT_LATENCY = 10;

  // Pointer width for a DEPTH-entry buffer; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hrfp_mult_issue_if.sv
// Handshake bundle between the issue front end, its upstream/downstream
// users and the multiplier pipeline.
//   in_valid/in_ready/in_a/in_b : operand stream into the front end
//   out_valid/out_ready/out_data: result stream out of the front end
//   pipe_op_a/pipe_op_b         : registered operands to the pipeline
//   pipe_result                 : pipeline product
// slave  = front end view, master = environment (source, sink, pipeline).
interface hrfp_mult_issue_if
  import hrfp_mult_issue_pkg::*;
#(
  parameter int WIDTH = HRFP_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] pipe_op_a;
  logic [WIDTH-1:0] pipe_op_b;
  logic [WIDTH-1:0] pipe_result;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, pipe_result,
    output in_ready, out_valid, out_data, pipe_op_a, pipe_op_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, pipe_result,
    input  in_ready, out_valid, out_data, pipe_op_a, pipe_op_b
  );
endinterface

// File: rtl/hrfp_sync_fifo.sv
// Single-clock FIFO, asynchronous active-high reset.
//   wr_en/wr_data : push (dropped when full unless a pop happens the same cycle)
//   rd_en/rd_data : pop of the head; rd_data reads 0 while empty
//   count         : number of stored entries
//   full/empty    : occupancy flags
module hrfp_sync_fifo
  import hrfp_mult_issue_pkg::*;
#(
  parameter  int WIDTH = HRFP_WIDTH,
  parameter  int DEPTH = 16,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  // Pointers wrap modulo DEPTH, which also covers non-power-of-2 pointer spans.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Occupancy flags and qualified push/pop; a simultaneous push+pop is legal
  // at both the full and the empty boundary and moves both pointers.
  always_comb begin
    full    = (count_r == CW'(DEPTH));
    empty   = (count_r == {CW{1'b0}});
    count   = count_r;
    do_wr_s = wr_en && (!full  || rd_en);
    do_rd_s = rd_en && (!empty || wr_en);
  end

  // Head of queue; forced to zero while nothing is stored.
  always_comb begin
    if (empty) begin
      rd_data = {WIDTH{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and count bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (do_rd_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      count_r <= count_r + CW'(do_wr_s) - CW'(do_rd_s);
    end
  end

endmodule

// File: rtl/hrfp_mult_issue.sv
// Issue/collect front end for the fixed-latency, non-stallable HRFP
// multiplier pipeline.
//   clk, rst  : clock and asynchronous active-high reset
//   bus       : operand stream in, result stream out, pipeline operands/result
//   overflow  : sticky flag, set if a result ever finds the FIFO full
// A pair is issued only when a FIFO slot is reserved for its result, so
// downstream backpressure can never cost a pipeline result.
module hrfp_mult_issue
  import hrfp_mult_issue_pkg::*;
#(
  parameter int WIDTH   = HRFP_WIDTH,
  parameter int LATENCY = HRFP_MULT_LATENCY,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hrfp_mult_issue_if.slave         bus,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0] valid_sr_r;
  logic               wr_pend_r;
  logic [CW-1:0]      inflight_r;
  logic [CW-1:0]      occupancy_s;
  logic [CW:0]        credit_s;
  logic               accept_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [WIDTH-1:0]   pipe_op_a_r;
  logic [WIDTH-1:0]   pipe_op_b_r;
  logic               overflow_r;

  // Credit check uses registered state only, so in_ready never follows
  // in_valid or a same-cycle pop.
  always_comb begin
    credit_s     = {1'b0, inflight_r} + {1'b0, occupancy_s};
    bus.in_ready = (credit_s < (CW + 1)'(DEPTH));
    accept_s     = bus.in_valid && bus.in_ready;
    bus.out_valid = !fifo_empty_s;
    pop_s        = bus.out_valid && bus.out_ready;
    bus.pipe_op_a = pipe_op_a_r;
    bus.pipe_op_b = pipe_op_b_r;
    overflow     = overflow_r;
  end

  // Operand registers, valid tracking and credit counter. wr_pend_r is the
  // extra stage between "last valid stage set" and the edge at which the
  // product is actually present on pipe_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_op_a_r <= {WIDTH{1'b0}};
      pipe_op_b_r <= {WIDTH{1'b0}};
      valid_sr_r  <= {LATENCY{1'b0}};
      wr_pend_r   <= 1'b0;
      inflight_r  <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        pipe_op_a_r <= bus.in_a;
        pipe_op_b_r <= bus.in_b;
      end
      valid_sr_r <= LATENCY'({valid_sr_r, accept_s});
      wr_pend_r  <= valid_sr_r[LATENCY-1];
      inflight_r <= inflight_r + CW'(accept_s) - CW'(wr_pend_r);
    end
  end

  // Sticky error: a result arriving with no room; the FIFO drops it itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (wr_pend_r && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  hrfp_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_pend_r),
    .wr_data (bus.pipe_result),
    .rd_en   (pop_s),
    .rd_data (bus.out_data),
    .count   (occupancy_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

endmodule

// File: tb/tb_hrfp_mult_issue.sv
// Self-checking bench for hrfp_mult_issue with a small configuration and a
// 3-stage XOR stub in place of the multiplier pipeline.
module tb_hrfp_mult_issue;

  localparam int W = 32;
  localparam int L = 3;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overflow;

  hrfp_mult_issue_if #(.WIDTH(W)) bus ();

  hrfp_mult_issue #(
    .WIDTH   (W),
    .LATENCY (L),
    .DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (overflow)
  );

  // Pipeline stub: product appears L edges after the operands change.
  logic [W-1:0] s1, s2, s3;
  always_ff @(posedge clk) begin
    s1 <= bus.pipe_op_a ^ bus.pipe_op_b;
    s2 <= s1;
    s3 <= s2;
  end
  assign bus.pipe_result = s3;

  always #5 clk = ~clk;

  // Reference model: every accepted pair is one outstanding item, visible
  // at the output from L+1 edges after acceptance until popped, in order.
  logic [W-1:0] exp_q [$];
  int           rdy_q [$];
  int           cyc;
  int           acc_cnt;
  logic [W-1:0] last_a, last_b;
  int           checks;
  int           errors;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    logic exp_ready, exp_valid, acc, pop;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    exp_ready = (exp_q.size() < D);
    exp_valid = (rdy_q.size() > 0) && (rdy_q[0] <= cyc);
    check("in_ready", W'(bus.in_ready), W'(exp_ready));
    check("out_valid", W'(bus.out_valid), W'(exp_valid));
    if (exp_valid) check("out_data", bus.out_data, exp_q[0]);
    check("overflow", W'(overflow), W'(1'b0));
    check("pipe_op_a", bus.pipe_op_a, last_a);
    check("pipe_op_b", bus.pipe_op_b, last_b);
    acc = v && exp_ready;
    pop = ordy && exp_valid;
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(a ^ b);
      rdy_q.push_back(cyc + L + 1);
      last_a = a;
      last_b = b;
      acc_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_cnt = 0;
    last_a = '0; last_b = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", W'(bus.in_ready), W'(1'b1));
    check("rst_out_valid", W'(bus.out_valid), W'(1'b0));
    check("rst_out_data", bus.out_data, 32'h0000_0000);
    check("rst_overflow", W'(overflow), W'(1'b0));
    check("rst_pipe_op_a", bus.pipe_op_a, 32'h0000_0000);

    // Single op: result visible after edge 4, then gone after the pop
    step(1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Back-to-back issue with a free-running sink
    for (int i = 0; i < 8; i++) begin
      while (exp_q.size() >= D) step(1'b1, W'(i), 32'h0000_0100, 1'b1);
      step(1'b1, W'(i), 32'h0000_0100, 1'b1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Backpressure: source stalls after D accepts, FIFO fills without overflow
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 32'hA5A5_0000 + W'(i), 32'h0000_FFFF, 1'b0);
    check("bp_accepts", W'(acc_cnt), W'(D));

    // Full: one pop frees exactly one credit for one new accept
    acc_cnt = 0;
    step(1'b1, 32'h1111_0000, 32'h0000_2222, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h3333_0000, 32'h0000_4444, 1'b0);
    check("pop_refill_accepts", W'(acc_cnt), W'(1));
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Reset mid-flight: no stale result may surface
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD_0000 + W'(i), 32'h0000_BEEF, 1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h1234_0000, 32'h0000_00FF, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Random traffic with random downstream stalls
    acc_cnt = 0;
    for (int n = 0; n < 20000 && acc_cnt < 1000; n++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    check("random_accepts", W'(acc_cnt), W'(1000));
    for (int i = 0; i < 4 * D + L + 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    check("final_out_valid", W'(bus.out_valid), W'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
